// File: rtl/fir_tdm_filter.sv
// Time-multiplexed FIR: one signed MAC walks TAPS coefficients per accepted sample,
// with a circular delay line, a writable coefficient bank and valid/ready on both sides.
module fir_tdm_filter #(
  parameter int DATA_W    = 16,
  parameter int COEFF_W   = 16,
  parameter int TAPS      = 32,
  parameter int OUT_SHIFT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_sample,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [DATA_W-1:0]  out_data,
  input  logic                      coeff_we,
  input  logic [$clog2(TAPS)-1:0]   coeff_addr,
  input  logic signed [COEFF_W-1:0] coeff_wdata,
  output logic                      busy
);
  localparam int AW    = $clog2(TAPS);
  localparam int PW    = DATA_W + COEFF_W;
  localparam int ACC_W = PW + $clog2(TAPS);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({(DATA_W-1){1'b1}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                    state;
  logic [AW-1:0]             wp, idx, rd_ptr;
  logic signed [DATA_W-1:0]  dline [TAPS];
  logic signed [COEFF_W-1:0] coeff [TAPS];
  logic signed [ACC_W-1:0]   acc, acc_nxt, acc_sh;
  logic signed [PW-1:0]      prod;
  logic signed [DATA_W-1:0]  sat_out;
  logic                      accept, last;

  assign busy   = (state != IDLE);
  assign accept = in_ready & in_valid;
  assign last   = (idx == AW'(TAPS - 1));

  // (wp - idx) mod TAPS, computed one bit wider so non-power-of-two TAPS wraps correctly
  always_comb begin
    if (idx > wp) rd_ptr = AW'({1'b0, wp} + (AW+1)'(TAPS) - {1'b0, idx});
    else          rd_ptr = wp - idx;
  end

  assign prod    = PW'(dline[rd_ptr]) * PW'(coeff[idx]);
  assign acc_nxt = acc + ACC_W'(prod);
  assign acc_sh  = acc_nxt >>> OUT_SHIFT;

  always_comb begin
    if (acc_sh > SAT_MAX)      sat_out = {1'b0, {(DATA_W-1){1'b1}}};
    else if (acc_sh < SAT_MIN) sat_out = {1'b1, {(DATA_W-1){1'b0}}};
    else                       sat_out = acc_sh[DATA_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      wp        <= '0;
      idx       <= '0;
      acc       <= '0;
      for (int i = 0; i < TAPS; i++) begin
        dline[i] <= '0;
        coeff[i] <= '0;
      end
    end else begin
      // coefficient bank is only writable while idle; the new value is seen by a same-edge accept
      if (state == IDLE && coeff_we) coeff[coeff_addr] <= coeff_wdata;
      case (state)
        IDLE: begin
          in_ready <= ~accept;
          if (accept) begin
            dline[wp] <= in_sample;
            acc       <= '0;
            idx       <= '0;
            state     <= MAC;
          end
        end
        MAC: begin
          acc <= acc_nxt;
          idx <= idx + AW'(1);
          if (last) begin
            out_data  <= sat_out;
            out_valid <= 1'b1;
            wp        <= (wp == AW'(TAPS - 1)) ? '0 : wp + AW'(1);
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_tdm_filter.sv
// Bench for fir_tdm_filter: two instances (OUT_SHIFT 15 and 0) share stimulus and are
// checked against a sum-of-products model over a sample history.
module tb_fir_tdm_filter;
  localparam int TAPS = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b1, coeff_we = 1'b0;
  logic signed [15:0] in_sample = '0, coeff_wdata = '0;
  logic [4:0] coeff_addr = '0;
  logic in_ready, out_valid, busy;
  logic in_ready0, out_valid0, busy0;
  logic signed [15:0] out_data, out_data0;

  always #5 clk = ~clk;

  fir_tdm_filter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .coeff_we(coeff_we),
    .coeff_addr(coeff_addr), .coeff_wdata(coeff_wdata), .busy(busy));

  fir_tdm_filter #(.OUT_SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_sample(in_sample),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .coeff_we(coeff_we),
    .coeff_addr(coeff_addr), .coeff_wdata(coeff_wdata), .busy(busy0));

  typedef struct {
    logic signed [15:0] x;
    logic signed [15:0] e0;
    logic signed [15:0] e15;
  } vec_t;

  int     n_vec = 0, n_bad = 0;
  longint hist [TAPS];
  longint coef [TAPS];
  vec_t   tbl  [TAPS];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin hist[k] = 0; coef[k] = 0; end
  endtask

  task automatic model_accept(input logic signed [15:0] x, output longint e0, output longint e15);
    longint acc = 0;
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    for (int k = 0; k < TAPS; k++) acc += coef[k] * hist[k];
    e0  = sat16(acc);
    e15 = sat16(acc >>> 15);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; coeff_we = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_data_s0", out_data0, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
  endtask

  task automatic wcoef(input logic [4:0] a, input logic signed [15:0] v);
    coeff_we = 1'b1; coeff_addr = a; coeff_wdata = v;
    @(negedge clk);
    coeff_we = 1'b0;
    coef[a] = v;
  endtask

  // wr_mode: 0 none, 1 write during MAC (must be dropped), 2 write on the accept edge (applies)
  task automatic do_sample(input logic signed [15:0] x, input int hold, input int wr_mode,
                           input logic [4:0] wa, input logic signed [15:0] wv,
                           output logic signed [15:0] g0, output logic signed [15:0] g15);
    int cyc;
    longint e0, e15;
    logic signed [15:0] held;
    cyc = 0;
    while (!in_ready && cyc < 50) begin @(negedge clk); cyc++; end
    chk("in_ready_wait", in_ready, 1);
    out_ready = (hold == 0);
    in_valid = 1'b1; in_sample = x;
    if (wr_mode == 2) begin
      coeff_we = 1'b1; coeff_addr = wa; coeff_wdata = wv; coef[wa] = wv;
    end
    @(negedge clk);
    in_valid = 1'b0; coeff_we = 1'b0;
    model_accept(x, e0, e15);
    cyc = 1;
    while (!out_valid && cyc < 3 * TAPS) begin
      if (cyc == 2) begin chk("mac_busy", busy, 1); chk("mac_in_ready", in_ready, 0); end
      if (wr_mode == 1 && cyc == 3) begin
        coeff_we = 1'b1; coeff_addr = wa; coeff_wdata = wv;
      end else coeff_we = 1'b0;
      @(negedge clk);
      cyc++;
    end
    coeff_we = 1'b0;
    chk("latency", cyc, TAPS + 1);
    chk("out_valid_s0", out_valid0, 1);
    g0 = out_data0; g15 = out_data;
    chk("out_data_s0", out_data0, e0);
    chk("out_data", out_data, e15);
    held = out_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_stable", out_data, held);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_in_ready_s0", in_ready0, 0);
      chk("bp_busy", busy, 1);
      chk("bp_busy_s0", busy0, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic signed [15:0] g0, g15;
    int seen;
    for (int i = 0; i < TAPS; i++) begin
      tbl[i].x   = (i == 0) ? 16'sd1 : 16'sd0;
      tbl[i].e0  = 16'(i + 1);
      tbl[i].e15 = 16'sd0;
    end

    // impulse response, coeff[k] = k+1
    do_reset();
    for (int k = 0; k < TAPS; k++) wcoef(5'(k), 16'(k + 1));
    for (int i = 0; i < TAPS; i++) begin
      do_sample(tbl[i].x, 0, 0, 0, 0, g0, g15);
      chk("imp_s0", g0, tbl[i].e0);
      chk("imp", g15, tbl[i].e15);
    end

    // saturation at both rails
    for (int k = 0; k < TAPS; k++) wcoef(5'(k), 16'sh7FFF);
    repeat (TAPS) do_sample(16'sh7FFF, 0, 0, 0, 0, g0, g15);
    chk("sat_pos_s0", g0, 32767);
    chk("sat_pos", g15, 32767);
    repeat (TAPS) do_sample(16'sh8000, 0, 0, 0, 0, g0, g15);
    chk("sat_neg_s0", g0, -32768);
    chk("sat_neg", g15, -32768);

    // backpressure in OUT
    do_sample(16'sd100, 10, 0, 0, 0, g0, g15);

    // coefficient write ignored while busy, honoured while idle
    do_reset();
    wcoef(0, 16'sd3);
    do_sample(16'sd10, 0, 1, 0, 16'sd5, g0, g15);
    chk("busy_wr_first", g0, 30);
    do_sample(16'sd20, 0, 0, 0, 0, g0, g15);
    chk("busy_wr_dropped", g0, 60);
    wcoef(0, 16'sd5);
    do_sample(16'sd1, 0, 0, 0, 0, g0, g15);
    chk("idle_wr_applied", g0, 5);
    do_sample(16'sd2, 0, 2, 0, 16'sd7, g0, g15);
    chk("same_edge_wr", g0, 14);

    // wrap past 31 with Q15 half gain
    do_reset();
    wcoef(0, 16'sh4000);
    for (int i = 0; i < 40; i++) begin
      do_sample(16'sd1000, 0, 0, 0, 0, g0, g15);
      chk("q15_half", g15, 500);
    end

    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < TAPS; k++) wcoef(5'(k), 16'($urandom));
    for (int i = 0; i < 60; i++)
      do_sample(16'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                5'($urandom), 16'($urandom), g0, g15);

    // reset in the middle of MAC
    do_reset();
    wcoef(0, 16'sd7);
    in_valid = 1'b1; in_sample = 16'sd9;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    seen = 0;
    repeat (60) begin @(negedge clk); if (out_valid) seen++; end
    chk("midrst_no_pulse", seen, 0);
    do_sample(16'sd1, 0, 0, 0, 0, g0, g15);
    chk("midrst_coeff_cleared", g0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/fir_tdm_filter.md
# fir_tdm_filter

Parametrised, time-multiplexed FIR filter: a single signed multiply-accumulate unit iterates over `TAPS` coefficients per input sample. Tap count, data width and coefficient width are parameters. Coefficients live in a writable register bank rather than on per-tap input ports. Sits in the audio/sample datapath between the sample source and downstream consumers, with valid/ready handshakes on both sides, so it can stall under backpressure.

## Interface
- `DATA_W`, 16, sample and output width (signed two's complement)
- `COEFF_W`, 16, coefficient width (signed)
- `TAPS`, 32, number of taps (≥2)
- `OUT_SHIFT`, 15, arithmetic right shift applied to the accumulator before saturation
- `ACC_W`, DATA_W+COEFF_W+$clog2(TAPS), accumulator width (derived, not overridden)

Ports:
- `clk`  in  1  clock; all logic rising-edge
- `rst_n`  in  1  reset; one clock; asynchronous, active-low
- `in_valid`  in  1  `in_sample` is valid
- `in_ready`  out  1  block can accept a sample
- `in_sample`  in  DATA_W  signed input sample
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  consumer accepts `out_data`
- `out_data`  out  DATA_W  signed filtered sample, saturated
- `coeff_we`  in  1  coefficient write strobe
- `coeff_addr`  in  $clog2(TAPS)  coefficient index k (weights x[n-k])
- `coeff_wdata`  in  COEFF_W  signed coefficient value
- `busy`  out  1  high in any state other than IDLE

## Operation
- **Storage.** Delay line of `TAPS` samples, implemented as a circular buffer with write pointer `wp`. The coefficient bank holds `TAPS` words.
- **States:** IDLE, MAC, OUT.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`: write `in_sample` at `wp`, clear `acc`, set `idx`=0, go to MAC.
- **MAC**
  - Each cycle: `acc += coeff[idx] * x[n-idx]`, with the sample read at `(wp - idx) mod TAPS`. The product is full-precision signed and sign-extended to `ACC_W`.
  - `idx` increments each cycle. After the `idx`=TAPS-1 term, load `out_data`, advance `wp` (wrapping TAPS-1 → 0) and go to OUT.
- **Output formatting.** `out_data` = saturate(`acc` >>> `OUT_SHIFT`) to the range [-2^(DATA_W-1), 2^(DATA_W-1)-1]. No rounding (truncation toward −∞).
- **OUT**
  - `out_valid`=1.
  - `out_data` is held stable until `out_ready`=1, then go to IDLE.
- **Coefficient writes**
  - Take effect only in IDLE, on the clock edge.
  - Writes in MAC or OUT are ignored (dropped, not queued).
  - A write and a sample accept in the same IDLE cycle: the write lands first, so the new coefficient applies to that sample.
- **Overflow.** Accumulator width guarantees no overflow for any inputs. Saturation applies only at the output.

## Timing
- **Reset values:** state IDLE, `in_ready`=0 during reset then 1, `out_valid`=0, `out_data`=0, `busy`=0, `wp`=0. All delay-line entries and coefficients are 0.
- **Accept.** A sample accepted at edge E0 enters MAC in cycle 1 after E0. MAC lasts exactly `TAPS` cycles.
- **Latency.** `out_valid` rises in cycle `TAPS`+1 after E0, i.e. accept-to-`out_valid` latency is `TAPS`+1 cycles.
- **Throughput.** With `out_ready` tied high, the OUT → IDLE transition takes one cycle and `in_ready` returns in cycle `TAPS`+2. Sustained rate is one sample per `TAPS`+2 cycles.
- **Handshake signals.** `in_ready` and `out_valid` are registered-state decodes with no combinational path from `in_valid`/`out_ready`. `busy` is a combinational decode of state.
- **Reset mid-operation.** Asserting `rst_n`=0 in any state aborts immediately (asynchronously). The partial result is discarded and the delay line and coefficients are cleared. No `out_valid` pulse is produced.

## Test plan
- **Impulse response.** `TAPS`=32, `OUT_SHIFT`=0, coeff[k]=k+1. Feed 1 followed by 31 zeros → outputs are 1, 2, …, 32 in order; each `out_valid` occurs 33 cycles after its accept.
- **Saturation.** `OUT_SHIFT`=0, all coeff=0x7FFF, 32 samples of 0x7FFF → `out_data`=0x7FFF. Same with samples 0x8000 → `out_data`=0x8000.
- **Backpressure.** Hold `out_ready`=0 for 10 cycles in OUT → `out_data` is stable, `in_ready`=0 and `busy`=1 throughout. Release → one transfer, then IDLE.
- **Coefficient write while busy.** Write coeff[0]=5 during MAC → it is ignored; the next output uses the old coeff[0]. The same write in IDLE takes effect on the next sample.
- **Wrap and Q15 scaling.** Default parameters, coeff[0]=0x4000 (0.5). Stream 40 samples of 1000 → each output is 500; `wp` wraps correctly past 31.
- **Reset mid-MAC.** Assert `rst_n` at MAC cycle 10 → `out_valid` never rises for that sample. After release, an impulse with coeff[0]=0 yields 0, confirming coefficients were cleared.
